// File: rtl/axis_pulse_scheduler_if.sv
// axis_pulse_scheduler_if: AXI-Stream link for the command input and the DAC sample output.
interface axis_pulse_scheduler_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_pulse_scheduler.sv
// axis_pulse_scheduler: queued {delay,width,amplitude} pulse sequencer feeding a DAC AXI-Stream.
// Define AXIS_PULSE_SCHED_LOOP_EN to add loop_en, which rewrites each popped command to the FIFO tail.
module axis_pulse_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int CMD_DEPTH  = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axis_pulse_scheduler_if.slave        s_cmd,
  axis_pulse_scheduler_if.master       m_axis,
  input  logic                         abort,
`ifdef AXIS_PULSE_SCHED_LOOP_EN
  input  logic                         loop_en,
`endif
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CMD_W = 2 * CNT_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0] LVL_ONE = 1;
  localparam logic [AW:0] FULL = CMD_DEPTH;
  typedef enum logic [1:0] {IDLE, GAP, PULSE} state_t;
  state_t state_q, state_d;
  logic [CMD_W-1:0] mem [CMD_DEPTH];
  logic [CMD_W-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, width_q, width_d, h_delay, h_width;
  logic [DATA_WIDTH-1:0] amp_q, amp_d, h_amp, tdata_q, tdata_d;
  logic tlast_q, tlast_d, run, beat, pop, push, wb, loop, done;
`ifdef AXIS_PULSE_SCHED_LOOP_EN
  assign loop = loop_en;
`else
  assign loop = 1'b0;
`endif
  assign head = mem[rd_ptr];
  assign {h_delay, h_width, h_amp} = head;
  assign beat = run && m_axis.tready;
  assign wb = loop && pop;
  assign s_cmd.tready = run && level != FULL && !wb;
  assign push = s_cmd.tvalid && s_cmd.tready && !abort;
  assign m_axis.tvalid = run;
  assign m_axis.tdata = tdata_q;
  assign m_axis.tlast = tlast_q;
  assign busy = state_q != IDLE || level != '0;
  assign cmd_level = level;
  // The registered sample is the one being offered; done means it is the command's last.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    width_d = width_q;
    amp_d = amp_q;
    tdata_d = '0;
    tlast_d = 1'b0;
    pop = 1'b0;
    done = state_q == IDLE || (cnt_q == '0 && (state_q == PULSE || width_q == '0));
    if (state_q == GAP && cnt_q == '0 && width_q != '0) begin
      state_d = PULSE;
      cnt_d = width_q - ONE;
      tdata_d = amp_q;
      tlast_d = width_q == ONE;
    end else if (!done) begin
      cnt_d = cnt_q - ONE;
      tdata_d = state_q == PULSE ? amp_q : '0;
      tlast_d = state_q == PULSE && cnt_q == ONE;
    end else if (level != '0) begin
      pop = beat && !abort;
      width_d = h_width;
      amp_d = h_amp;
      state_d = h_delay != '0 ? GAP : h_width != '0 ? PULSE : IDLE;
      cnt_d = h_delay != '0 ? h_delay - ONE : h_width != '0 ? h_width - ONE : '0;
      tdata_d = h_delay == '0 && h_width != '0 ? h_amp : '0;
      tlast_d = h_delay == '0 && h_width == ONE;
    end else begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      width_q <= '0;
      amp_q <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
    end else begin
      run <= 1'b1;
      if (abort) begin
        state_q <= IDLE;
        cnt_q <= '0;
        tdata_q <= '0;
        tlast_q <= 1'b0;
      end else if (beat) begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        width_q <= width_d;
        amp_q <= amp_d;
        tdata_q <= tdata_d;
        tlast_q <= tlast_d;
      end
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push || wb) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if ((push || wb) && !pop) level <= level + LVL_ONE;
      else if (pop && !(push || wb)) level <= level - LVL_ONE;
    end
  end
  // Write-back reads the head in the same cycle it is re-queued, so a full ring is safe.
  always_ff @(posedge aclk) begin
    if (push || wb) mem[wr_ptr] <= wb ? head : s_cmd.tdata;
  end
endmodule

// File: tb/tb_axis_pulse_scheduler.sv
// tb_axis_pulse_scheduler: directed table plus corner sequences for axis_pulse_scheduler.
module tb_axis_pulse_scheduler;
  localparam int DW = 16, CW = 16, DEPTH = 8, LW = $clog2(DEPTH) + 1;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic abort = 1'b0;
  logic loop_en = 1'b0;
  logic busy;
  logic [LW-1:0] cmd_level;
  int tests = 0;
  int fails = 0;
  axis_pulse_scheduler_if #(.W(2 * CW + DW)) cmd ();
  axis_pulse_scheduler_if #(.W(DW)) dac ();
  axis_pulse_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .CMD_DEPTH(DEPTH)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_cmd(cmd),
    .m_axis(dac),
    .abort(abort),
`ifdef AXIS_PULSE_SCHED_LOOP_EN
    .loop_en(loop_en),
`endif
    .busy(busy),
    .cmd_level(cmd_level)
  );
  always #5 aclk = ~aclk;
  typedef struct {
    logic v;
    int d, w, a;
    logic rdy;
    int e_data;
    logic e_last;
    int e_lvl;
    logic e_busy, e_crdy;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic v, int d, int w, int a, logic rdy, int ed, logic el, int elv, logic eb, logic ec);
    vec_t r;
    r.v = v; r.d = d; r.w = w; r.a = a; r.rdy = rdy;
    r.e_data = ed; r.e_last = el; r.e_lvl = elv; r.e_busy = eb; r.e_crdy = ec;
    return r;
  endfunction
  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input int d, input int w, input int a, input logic rdy, input logic ab);
    @(negedge aclk);
    cmd.tvalid = v;
    cmd.tdata = {d[15:0], w[15:0], a[15:0]};
    dac.tready = rdy;
    abort = ab;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    cmd.tvalid = 1'b0;
    cmd.tdata = '0;
    cmd.tlast = 1'b0;
    dac.tready = 1'b1;
    // delay=3 width=4: three zeros then four amplitude samples
    tbl.push_back(mk(1, 3, 4, 32000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 1));
    repeat (3) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    repeat (3) tbl.push_back(mk(0, 0, 0, 0, 1, 32000, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32000, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // back-to-back {0,2,1000},{1,1,-500} with a tready stall on the tlast sample
    tbl.push_back(mk(1, 0, 2, 1000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, -500, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1000, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1000, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1000, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1000, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, -500, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // zero-delay zero-width command is discarded
    tbl.push_back(mk(1, 0, 0, 555, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    repeat (3) @(negedge aclk);
    check("rst tvalid", dac.tvalid, 0);
    check("rst s_cmd_tready", cmd.tready, 0);
    check("rst tdata", dac.tdata, 0);
    check("rst tlast", dac.tlast, 0);
    check("rst busy", busy, 0);
    check("rst cmd_level", cmd_level, 0);
    aresetn = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    check("post-rst tvalid", dac.tvalid, 1);
    check("post-rst s_cmd_tready", cmd.tready, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      check($sformatf("idle%0d tdata", i), $signed(dac.tdata), 0);
      check($sformatf("idle%0d busy", i), busy, 0);
    end
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].rdy, 0);
      check($sformatf("vec%0d tdata", i), $signed(dac.tdata), tbl[i].e_data);
      check($sformatf("vec%0d tlast", i), dac.tlast, tbl[i].e_last);
      check($sformatf("vec%0d level", i), cmd_level, tbl[i].e_lvl);
      check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d s_cmd_tready", i), cmd.tready, tbl[i].e_crdy);
      check($sformatf("vec%0d tvalid", i), dac.tvalid, 1);
    end
    // fill with tready low: eight accepted, ninth refused
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 1, 100 + k, 0, 0);
      check($sformatf("fill%0d s_cmd_tready", k), cmd.tready, k < 8);
      check($sformatf("fill%0d tdata", k), $signed(dac.tdata), 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    check("full level", cmd_level, 8);
    check("full s_cmd_tready", cmd.tready, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("drain start tdata", $signed(dac.tdata), 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      check($sformatf("drain%0d tdata", k), $signed(dac.tdata), 100 + k);
      check($sformatf("drain%0d tlast", k), dac.tlast, 1);
      check($sformatf("drain%0d level", k), cmd_level, 7 - k);
    end
    drive(0, 0, 0, 0, 1, 0);
    check("drained tdata", $signed(dac.tdata), 0);
    check("drained busy", busy, 0);
    // abort mid-pulse, with a command write in the abort cycle
    drive(1, 0, 100, 2000, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      check($sformatf("pulse%0d tdata", k), $signed(dac.tdata), 2000);
      check($sformatf("pulse%0d tlast", k), dac.tlast, 0);
    end
    drive(1, 0, 1, 77, 1, 1);
    drive(0, 0, 0, 0, 1, 0);
    check("abort tdata", $signed(dac.tdata), 0);
    check("abort tlast", dac.tlast, 0);
    check("abort level", cmd_level, 0);
    check("abort busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      check($sformatf("post-abort%0d tdata", k), $signed(dac.tdata), 0);
      check($sformatf("post-abort%0d level", k), cmd_level, 0);
    end
`ifdef AXIS_PULSE_SCHED_LOOP_EN
    loop_en = 1'b1;
    drive(1, 0, 1, 7, 0, 0);
    drive(1, 0, 1, 9, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("loop level", cmd_level, 2);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      check($sformatf("loop%0d tdata", i), $signed(dac.tdata), (i % 2) ? 9 : 7);
      check($sformatf("loop%0d level", i), cmd_level, 2);
      check($sformatf("loop%0d s_cmd_tready", i), cmd.tready, 0);
    end
    loop_en = 1'b0;
    repeat (4) drive(0, 0, 0, 0, 1, 0);
    check("unloop level", cmd_level, 0);
    check("unloop tdata", $signed(dac.tdata), 0);
    check("unloop busy", busy, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
